// File: rtl/michaelbell_latch_mem_if.sv
// Pin bundle of the latch-RAM tile: select, address/control, write data and outputs.
// master drives the dedicated inputs; slave is the tile itself.
interface michaelbell_latch_mem_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/michaelbell_latch_mem.sv
// 64 x 8 latch-based RAM tile: write captured on clk rise, stored during clk low; registered read.
// Optional build macro LATCH_MEM_RESET_CLEAR_EN forces every byte to 0 while rst_n is low.
module michaelbell_latch_mem_row (
    input  logic       gate,
    input  logic       clr_n,
    input  logic [7:0] d,
    output logic [7:0] q
);
`ifdef LATCH_MEM_RESET_CLEAR_EN
    always_latch begin
        if (!clr_n)
            q <= 8'h00;
        else if (gate)
            q <= d;
    end
`else
    logic unused_clr_n;
    assign unused_clr_n = clr_n;

    always_latch begin
        if (gate)
            q <= d;
    end
`endif
endmodule

module michaelbell_latch_mem (
    input  logic                  clk,
    input  logic                  rst_n,
    michaelbell_latch_mem_if.slave bus
);
    localparam int DEPTH = 64;
    localparam int DW    = 8;

    logic                      pending;
    logic [DEPTH-1:0]          wr_sel;
    logic [DW-1:0]             wr_data;
    logic [DW-1:0]             rd_data;
    logic [DEPTH-1:0]          gate;
    logic [DEPTH-1:0][DW-1:0]  rows;
    logic [5:0]                addr;
    logic                      wr_en;
    logic                      unused_pins;

    assign addr        = bus.ui_in[5:0];
    assign wr_en       = bus.ui_in[7];
    assign unused_pins = &{1'b0, bus.ena, bus.ui_in[6]};

    // Row select is a registered one-hot, and pending only moves while clk is
    // high, so the gate cannot glitch during the transparent low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
            rd_data <= '0;
        end else begin
            pending <= wr_en;
            if (wr_en) begin
                wr_sel  <= 64'(1) << addr;
                wr_data <= bus.uio_in;
            end
            rd_data <= rows[addr];
        end
    end

    assign gate = {DEPTH{~clk & pending}} & wr_sel;

    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        michaelbell_latch_mem_row u_row (
            .gate  (gate[i]),
            .clr_n (rst_n),
            .d     (wr_data),
            .q     (rows[i])
        );
    end

    assign bus.uo_out  = rd_data;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;
endmodule

// File: tb/tb_michaelbell_latch_mem.sv
// Bench for the latch-RAM tile: directed cases plus random traffic against an array model.
module tb_michaelbell_latch_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    logic [7:0] model_mem [64];
    bit         model_ok  [64];
    bit         wr_open;
    int         wr_open_addr;

    michaelbell_latch_mem_if bus ();

    michaelbell_latch_mem dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, edge reads old contents, write lands afterwards.
    task automatic step(input string tag, input bit wr, input logic [5:0] a,
                        input logic [7:0] d, input bit b6 = 1'b0, input bit en = 1'b1);
        logic [7:0] exp;
        bit         known;
        bus.ui_in  = {wr, b6, a};
        bus.uio_in = d;
        bus.ena    = en;
        @(posedge clk);
        exp   = model_mem[a];
        known = model_ok[a];
        if (wr) begin
            model_mem[a] = d;
            model_ok[a]  = 1'b1;
        end
        wr_open      = wr;
        wr_open_addr = a;
        @(negedge clk);
        if (known)
            check(tag, bus.uo_out, exp);
    endtask

    task automatic do_reset(input int cycles);
        if (wr_open)
            model_ok[wr_open_addr] = 1'b0;
        wr_open = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_uo_out", bus.uo_out, 8'h00);
        repeat (cycles) @(negedge clk);
        check("rst_uo_hold", bus.uo_out, 8'h00);
        check("rst_uio_oe", bus.uio_oe, 8'h00);
        check("rst_uio_out", bus.uio_out, 8'h00);
`ifdef LATCH_MEM_RESET_CLEAR_EN
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = 8'h00;
            model_ok[i]  = 1'b1;
        end
`endif
        rst_n = 1'b1;
    endtask

    initial begin
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        wr_open    = 1'b0;
        wr_open_addr = 0;
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = 8'h00;
            model_ok[i]  = 1'b0;
        end
        @(negedge clk);
        do_reset(2);

        // single write then read
        step("wr_05", 1'b1, 6'h05, 8'hA5);
        step("rd_05", 1'b0, 6'h05, 8'h00);
        check("rd_05_val", bus.uo_out, 8'hA5);

        // fill all, read all
        for (int i = 0; i < 64; i++)
            step("fill", 1'b1, 6'(i), 8'(i) ^ 8'h3C);
        for (int i = 0; i < 64; i++) begin
            step("readback", 1'b0, 6'(i), 8'h00);
            check("readback_val", bus.uo_out, 8'(i) ^ 8'h3C);
        end

        // read-during-write on the same address returns old data
        step("wr_10a", 1'b1, 6'h10, 8'h11);
        step("wr_10b", 1'b1, 6'h10, 8'h22);
        check("rdw_old", bus.uo_out, 8'h11);
        step("rd_10", 1'b0, 6'h10, 8'h00);
        check("rdw_new", bus.uo_out, 8'h22);

        // back-to-back writes, same address: last wins
        step("b2b_a", 1'b1, 6'h11, 8'h01);
        step("b2b_b", 1'b1, 6'h11, 8'h02);
        step("b2b_c", 1'b1, 6'h11, 8'h03);
        step("b2b_rd", 1'b0, 6'h11, 8'h00);
        check("b2b_last", bus.uo_out, 8'h03);

        // contents across reset
        step("wr_20", 1'b1, 6'h20, 8'h77);
        step("idle", 1'b0, 6'h00, 8'h00);
        do_reset(2);
        step("rd_20", 1'b0, 6'h20, 8'h00);
`ifdef LATCH_MEM_RESET_CLEAR_EN
        check("rd_20_after_rst", bus.uo_out, 8'h00);
`else
        check("rd_20_after_rst", bus.uo_out, 8'h77);
`endif

        // reserved bit and ena have no effect
        step("wr_3f", 1'b1, 6'h3F, 8'hFF, 1'b1, 1'b0);
        step("rd_3f", 1'b0, 6'h3F, 8'h00, 1'b1, 1'b0);
        check("rd_3f_val", bus.uo_out, 8'hFF);

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset(1);
            else
                step("rand", 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                     8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // final sweep of everything the model knows
        for (int i = 0; i < 64; i++)
            step("sweep", 1'b0, 6'(i), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
